cart_mapper: RTL and testbench

- Cartridge bank-switch mapper between the 6502 address bus and the 16 KB cartridge ROM / 128-byte cart RAM.
- Tracks the image size written by the SPI loader and decodes hotspot accesses for the 2K, 4K, F8, F6 and E0 schemes.
- Drives the ROM physical address and the SuperChip RAM selects.
- Replaces the inline bank logic in the system top level; consumes CPU bus and loader writes, feeds the ROM and cart RAM.

---
 rtl/cart_pkg.sv | 42 ++++
 rtl/cart_size_tracker.sv | 51 +++++
 rtl/cart_mapper.sv | 129 ++++++++++++
 tb/tb_cart_mapper.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared encodings for the cartridge mapper: image sizes, bank-switch schemes,
// hotspot addresses and SuperChip RAM windows.
package cart_pkg;

    localparam logic [1:0] SZ_2K  = 2'd0;
    localparam logic [1:0] SZ_4K  = 2'd1;
    localparam logic [1:0] SZ_8K  = 2'd2;
    localparam logic [1:0] SZ_16K = 2'd3;

    localparam logic [13:0] LIM_2K = 14'h0800;
    localparam logic [13:0] LIM_4K = 14'h1000;
    localparam logic [13:0] LIM_8K = 14'h2000;

    typedef enum logic [2:0] {
        SCH_2K,
        SCH_4K,
        SCH_F8,
        SCH_F6,
        SCH_E0
    } scheme_e;

    localparam logic [12:0] HS_F8_0  = 13'h1FF8;
    localparam logic [12:0] HS_F6_0  = 13'h1FF6;
    localparam logic [12:0] HS_E0_S0 = 13'h1FE0;

    localparam logic [12:0] SC_WR_BASE = 13'h1000;
    localparam logic [12:0] SC_RD_BASE = 13'h1080;

    localparam logic [2:0][2:0] E0_SLICE_INIT = {3'd2, 3'd1, 3'd0};

    function automatic scheme_e scheme_of(input logic [1:0] size, input logic e0_sel);
        scheme_e sch;
        case (size)
            SZ_2K:   sch = SCH_2K;
            SZ_4K:   sch = SCH_4K;
            SZ_8K:   sch = e0_sel ? SCH_E0 : SCH_F8;
            default: sch = SCH_F6;
        endcase
        return sch;
    endfunction

endpackage

// File: rtl/cart_size_tracker.sv
// Follows the highest ROM address written by the loader and classifies the
// image size; a write to address 0 marks the start of a fresh image.
module cart_size_tracker
    import cart_pkg::*;
#(
    parameter int ROM_AW = 14
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_wr_i,
    input  logic [ROM_AW-1:0] ld_addr_i,
    output logic [1:0]        size_o
);

    logic [ROM_AW-1:0] max_addr_q, max_addr_d;
    logic [1:0]        size_q, size_d;

    always_comb begin
        max_addr_d = max_addr_q;
        if (ld_wr_i) begin
            if (ld_addr_i == '0) begin
                max_addr_d = '0;
            end else if (ld_addr_i > max_addr_q) begin
                max_addr_d = ld_addr_i;
            end
        end

        if (max_addr_q < ROM_AW'(LIM_2K)) begin
            size_d = SZ_2K;
        end else if (max_addr_q < ROM_AW'(LIM_4K)) begin
            size_d = SZ_4K;
        end else if (max_addr_q < ROM_AW'(LIM_8K)) begin
            size_d = SZ_8K;
        end else begin
            size_d = SZ_16K;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_addr_q <= '0;
            size_q     <= SZ_2K;
        end else begin
            max_addr_q <= max_addr_d;
            size_q     <= size_d;
        end
    end

    assign size_o = size_q;

endmodule

// File: rtl/cart_mapper.sv
// Bank-switch mapper: decodes 2K/4K/F8/F6/E0 hotspots from the CPU bus,
// drives the ROM physical address and the SuperChip cart RAM selects.
module cart_mapper
    import cart_pkg::*;
#(
    parameter int ROM_AW        = 14,
    parameter int SC_DEPTH_LOG2 = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [12:0]              cpu_addr_i,
    input  logic                     cpu_rnw_i,
    input  logic                     bus_strobe_i,
    input  logic                     ld_active_i,
    input  logic                     ld_wr_i,
    input  logic [ROM_AW-1:0]        ld_addr_i,
    input  logic                     e0_sel_i,
    input  logic                     sc_en_i,
    output logic [ROM_AW-1:0]        rom_addr_o,
    output logic                     cart_ram_cs_o,
    output logic                     cart_ram_we_o,
    output logic [SC_DEPTH_LOG2-1:0] cart_ram_addr_o,
    output logic [1:0]               size_o,
    output logic [1:0]               bank_o
);

    logic [1:0]      size;
    scheme_e         scheme;
    logic            ld_active_q;
    logic [1:0]      bank_q, bank_d;
    logic [2:0][2:0] slices_q, slices_d;
    logic [2:0]      e0_bank;
    logic [12:0]     f6_off;
    logic            hs_en, load_done, sc_active, wr_win, rd_win;

    cart_size_tracker #(.ROM_AW(ROM_AW)) u_size_tracker (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ld_wr_i   (ld_wr_i),
        .ld_addr_i (ld_addr_i),
        .size_o    (size)
    );

    assign size_o    = size;
    assign scheme    = scheme_of(size, e0_sel_i);
    assign hs_en     = bus_strobe_i & cpu_addr_i[12] & ~ld_active_i;
    assign load_done = ld_active_q & ~ld_active_i;
    assign f6_off    = cpu_addr_i - HS_F6_0;

    // Bank state survives scheme changes; only end-of-load or reset re-initialises it.
    always_comb begin
        bank_d   = bank_q;
        slices_d = slices_q;
        if (load_done) begin
            case (scheme)
                SCH_F8:  bank_d = 2'd1;
                SCH_F6:  bank_d = 2'd3;
                SCH_E0:  slices_d = E0_SLICE_INIT;
                default: ;
            endcase
        end else if (hs_en) begin
            case (scheme)
                SCH_F8: begin
                    if (cpu_addr_i[12:1] == HS_F8_0[12:1]) bank_d = {1'b0, cpu_addr_i[0]};
                end
                SCH_F6: begin
                    if (f6_off < 13'd4) bank_d = f6_off[1:0];
                end
                SCH_E0: begin
                    if (cpu_addr_i[12:5] == HS_E0_S0[12:5]) begin
                        case (cpu_addr_i[4:3])
                            2'b00:   slices_d[0] = cpu_addr_i[2:0];
                            2'b01:   slices_d[1] = cpu_addr_i[2:0];
                            2'b10:   slices_d[2] = cpu_addr_i[2:0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_active_q <= 1'b0;
            bank_q      <= 2'd0;
            slices_q    <= E0_SLICE_INIT;
        end else begin
            ld_active_q <= ld_active_i;
            bank_q      <= bank_d;
            slices_q    <= slices_d;
        end
    end

    always_comb begin
        case (cpu_addr_i[11:10])
            2'd0:    e0_bank = slices_q[0];
            2'd1:    e0_bank = slices_q[1];
            2'd2:    e0_bank = slices_q[2];
            default: e0_bank = 3'd7;
        endcase

        rom_addr_o = '0;
        bank_o     = 2'd0;
        case (scheme)
            SCH_2K: rom_addr_o = ROM_AW'({3'b000, cpu_addr_i[10:0]});
            SCH_4K: rom_addr_o = ROM_AW'({2'b00, cpu_addr_i[11:0]});
            SCH_F8: begin
                rom_addr_o = ROM_AW'({1'b0, bank_q[0], cpu_addr_i[11:0]});
                bank_o     = {1'b0, bank_q[0]};
            end
            SCH_F6: begin
                rom_addr_o = ROM_AW'({bank_q, cpu_addr_i[11:0]});
                bank_o     = bank_q;
            end
            SCH_E0:  rom_addr_o = ROM_AW'({1'b0, e0_bank, cpu_addr_i[9:0]});
            default: ;
        endcase
    end

    assign sc_active       = sc_en_i & ((scheme == SCH_F8) | (scheme == SCH_F6));
    assign wr_win          = (cpu_addr_i[12:7] == SC_WR_BASE[12:7]);
    assign rd_win          = (cpu_addr_i[12:7] == SC_RD_BASE[12:7]);
    assign cart_ram_we_o   = sc_active & wr_win & bus_strobe_i & ~cpu_rnw_i;
    assign cart_ram_cs_o   = sc_active & rd_win;
    assign cart_ram_addr_o = cpu_addr_i[SC_DEPTH_LOG2-1:0];

endmodule

// File: tb/tb_cart_mapper.sv
// Scoreboard bench for cart_mapper: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_cart_mapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] cpu_addr;
    logic        cpu_rnw;
    logic        bus_strobe;
    logic        ld_active;
    logic        ld_wr;
    logic [13:0] ld_addr;
    logic        e0_sel;
    logic        sc_en;
    logic [13:0] rom_addr;
    logic        ram_cs;
    logic        ram_we;
    logic [6:0]  ram_addr;
    logic [1:0]  size;
    logic [1:0]  bank;

    int checks = 0;
    int errors = 0;

    typedef enum int {K_ROM, K_SIZE, K_BANK, K_WE, K_CS, K_RADDR} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    cart_mapper #(.ROM_AW(14), .SC_DEPTH_LOG2(7)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cpu_addr_i      (cpu_addr),
        .cpu_rnw_i       (cpu_rnw),
        .bus_strobe_i    (bus_strobe),
        .ld_active_i     (ld_active),
        .ld_wr_i         (ld_wr),
        .ld_addr_i       (ld_addr),
        .e0_sel_i        (e0_sel),
        .sc_en_i         (sc_en),
        .rom_addr_o      (rom_addr),
        .cart_ram_cs_o   (ram_cs),
        .cart_ram_we_o   (ram_we),
        .cart_ram_addr_o (ram_addr),
        .size_o          (size),
        .bank_o          (bank)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [12:0] addr, input logic rnw, input logic strobe);
        cpu_addr   = addr;
        cpu_rnw    = rnw;
        bus_strobe = strobe;
    endtask

    task automatic expectOutput(input string name, input kind_e kind, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        case (e.kind)
            K_ROM:   act = {18'b0, rom_addr};
            K_SIZE:  act = {30'b0, size};
            K_BANK:  act = {30'b0, bank};
            K_WE:    act = {31'b0, ram_we};
            K_CS:    act = {31'b0, ram_cs};
            default: act = {25'b0, ram_addr};
        endcase
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end

    task automatic loadImage(input int top);
        ld_active = 1'b1;
        tick();
        for (int a = 0; a < top; a += 64) begin
            ld_wr   = 1'b1;
            ld_addr = 14'(a);
            tick();
        end
        ld_addr = 14'(top);
        tick();
        ld_wr = 1'b0;
        tick();
        tick();
        ld_active = 1'b0;
        tick();
    endtask

    task automatic strobeHotspot(input logic [12:0] addr, input logic rnw);
        applyStimulus(addr, rnw, 1'b1);
        tick();
        applyStimulus(addr, rnw, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        ld_active = 1'b0;
        ld_wr     = 1'b0;
        ld_addr   = '0;
        e0_sel    = 1'b0;
        sc_en     = 1'b0;
        applyStimulus(13'h0000, 1'b1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        expectOutput("reset_size", K_SIZE, 0);
        expectOutput("reset_bank", K_BANK, 0);
        expectOutput("reset_we", K_WE, 0);
        expectOutput("reset_rom", K_ROM, 0);

        // 4K image: hotspot addresses are plain ROM reads
        loadImage(14'h0FFF);
        expectOutput("4k_size", K_SIZE, 1);
        applyStimulus(13'h1FF9, 1'b1, 1'b1);
        expectOutput("4k_rom_1ff9", K_ROM, 14'h0FF9);
        tick();
        applyStimulus(13'h1FF9, 1'b1, 1'b0);
        expectOutput("4k_bank", K_BANK, 0);

        // F8
        loadImage(14'h1FFF);
        applyStimulus(13'h1123, 1'b1, 1'b0);
        expectOutput("f8_size", K_SIZE, 2);
        expectOutput("f8_init_bank", K_BANK, 1);
        expectOutput("f8_rom_bank1", K_ROM, 14'h1123);
        tick();
        strobeHotspot(13'h1FF8, 1'b1);
        applyStimulus(13'h1123, 1'b1, 1'b0);
        expectOutput("f8_bank0", K_BANK, 0);
        expectOutput("f8_rom_bank0", K_ROM, 14'h0123);
        tick();
        strobeHotspot(13'h1FF9, 1'b1);
        applyStimulus(13'h1123, 1'b1, 1'b0);
        expectOutput("f8_bank1", K_BANK, 1);

        // F6
        loadImage(14'h3FFF);
        applyStimulus(13'h1ABC, 1'b1, 1'b0);
        expectOutput("f6_size", K_SIZE, 3);
        expectOutput("f6_init_bank", K_BANK, 3);
        expectOutput("f6_rom_bank3", K_ROM, 14'h3ABC);
        tick();
        strobeHotspot(13'h1FF7, 1'b0);
        applyStimulus(13'h1ABC, 1'b1, 1'b0);
        expectOutput("f6_bank1", K_BANK, 1);
        expectOutput("f6_rom_bank1", K_ROM, 14'h1ABC);
        tick();

        // SuperChip in F6
        sc_en = 1'b1;
        applyStimulus(13'h1005, 1'b0, 1'b1);
        expectOutput("sc_we_pulse", K_WE, 1);
        expectOutput("sc_ram_addr", K_RADDR, 7'h05);
        expectOutput("sc_cs_in_wr_win", K_CS, 0);
        tick();
        applyStimulus(13'h1005, 1'b0, 1'b0);
        expectOutput("sc_we_single", K_WE, 0);
        expectOutput("sc_bank_kept", K_BANK, 1);
        tick();
        applyStimulus(13'h1085, 1'b1, 1'b0);
        expectOutput("sc_cs_read", K_CS, 1);
        expectOutput("sc_we_read", K_WE, 0);
        tick();
        sc_en = 1'b0;
        applyStimulus(13'h1005, 1'b0, 1'b1);
        expectOutput("sc_off_we", K_WE, 0);
        tick();
        applyStimulus(13'h1085, 1'b1, 1'b0);
        expectOutput("sc_off_cs", K_CS, 0);
        tick();

        // hotspot ignored while loader holds the CPU
        ld_active = 1'b1;
        tick();
        strobeHotspot(13'h1FF8, 1'b1);
        applyStimulus(13'h1ABC, 1'b1, 1'b0);
        expectOutput("hold_bank_kept", K_BANK, 1);
        expectOutput("hold_rom", K_ROM, 14'h1ABC);
        tick();
        ld_active = 1'b0;
        tick();
        expectOutput("hold_end_bank", K_BANK, 3);
        expectOutput("hold_end_rom", K_ROM, 14'h3ABC);

        // E0
        e0_sel = 1'b1;
        loadImage(14'h1FFF);
        applyStimulus(13'h1410, 1'b1, 1'b0);
        expectOutput("e0_size", K_SIZE, 2);
        expectOutput("e0_bank_o", K_BANK, 0);
        expectOutput("e0_init_rom", K_ROM, 14'h0410);
        tick();
        strobeHotspot(13'h1FE5, 1'b1);
        tick();
        strobeHotspot(13'h1FEA, 1'b1);
        applyStimulus(13'h1010, 1'b1, 1'b0);
        expectOutput("e0_rom_s0", K_ROM, 14'h1410);
        tick();
        applyStimulus(13'h1410, 1'b1, 1'b0);
        expectOutput("e0_rom_s1", K_ROM, 14'h0810);
        tick();
        applyStimulus(13'h1810, 1'b1, 1'b0);
        expectOutput("e0_rom_s2", K_ROM, 14'h0810);
        tick();
        applyStimulus(13'h1C10, 1'b1, 1'b0);
        expectOutput("e0_rom_s3", K_ROM, 14'h1C10);
        tick();

        // scheme change E0 -> F8 keeps the held bank (3 -> bit0 = 1)
        e0_sel = 1'b0;
        applyStimulus(13'h1123, 1'b1, 1'b0);
        #1;
        expectOutput("swap_bank", K_BANK, 1);
        expectOutput("swap_rom", K_ROM, 14'h1123);
        tick();

        // reset in the middle of a load is asynchronous
        ld_active = 1'b1;
        tick();
        ld_wr   = 1'b1;
        ld_addr = 14'h3000;
        tick();
        ld_wr = 1'b0;
        tick();
        expectOutput("midload_size", K_SIZE, 3);
        expectOutput("midload_bank", K_BANK, 3);
        tick();
        rst_n = 1'b0;
        #1;
        expectOutput("async_rst_size", K_SIZE, 0);
        expectOutput("async_rst_bank", K_BANK, 0);
        expectOutput("async_rst_rom", K_ROM, 14'h0123);
        tick();
        ld_active = 1'b0;
        rst_n     = 1'b1;
        tick();
        expectOutput("post_rst_size", K_SIZE, 0);
        expectOutput("post_rst_bank", K_BANK, 0);

        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
